spi_cmd_engine: RTL and testbench
=================================

// Module: spi_cmd_engine
// PURPOSE
//  Parametrised SPI command decoder/dispatcher between the SPI slave and the framebuffer
//  write port. It decodes each 3-byte command (command, databyte1, databyte2) on spi_done.
//  Score updates go straight to the score register. Pixel writes and full-screen clears are
//  queued in an in-order FIFO and issued to the framebuffer, at most one write per clk.
// PARAMETERS
//  X_W        5   grid column index width (databyte2[X_W-1:0])
//  Y_W        5   grid row index width (databyte1[Y_W-1:0])
//  COLOR_W    3   colour bits taken from command[COLOR_W-1:0]; must be <=4
//  SCORE_W    10  score width, {databyte1, databyte2}[SCORE_W-1:0]; must be <=16
//  FIFO_DEPTH 4   queued framebuffer ops; power of two, >=2
// PORTS
//  clk           in   1         system clock
//  reset         in   1         asynchronous, active-low reset
//  spi_done      in   1         1-clk pulse, synchronous to clk: the three bytes are valid
//  command       in   8         [7:4] opcode, [3:0] argument
//  databyte1     in   8         row index / score high byte
//  databyte2     in   8         column index / score low byte
//  we            out  1         framebuffer write enable (registered)
//  waddr         out  X_W+Y_W   framebuffer address {row, col} (registered)
//  wdata         out  8         {zeros, colour} (registered)
//  score         out  SCORE_W   current score (registered)
//  score_update  out  1         1-clk pulse when score is loaded
//  busy          out  1         FSM in CLEAR, or FIFO non-empty
//  overflow      out  1         sticky: a queued op was dropped
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM IDLE. Reset works mid-operation: it aborts a clear
//   or queued op immediately, with no resume.
//  Opcodes are sampled only when spi_done=1:
//   4'h1 PIXEL: push {PIXEL, addr={databyte1[Y_W-1:0],databyte2[X_W-1:0]}, colour}.
//   4'h2 SCORE: score <= {databyte1,databyte2}[SCORE_W-1:0] and score_update=1 on the next
//    clk. This bypasses the FIFO and is never blocked.
//   4'h3 CLEAR: push {CLEAR, colour}.
//   4'hF ACK: overflow <= 0 on the next clk.
//   Any other opcode is ignored: no push, no flag.
//  FIFO push: accepted if not full, or if a pop occurs in the same clk.
//   Otherwise the op is dropped and overflow <= 1. Overflow is cleared only by ACK or reset.
//   Simultaneous ACK and drop: overflow ends at 1.
//  FSM IDLE: if the FIFO is non-empty, pop at clk t.
//   PIXEL: we=1, waddr/wdata = entry at t+1. Stay in IDLE, so back-to-back pixels issue
//    one write per clk.
//   CLEAR: enter CLEAR. Sweep counter k=0..2^(X_W+Y_W)-1, giving we=1, waddr=k,
//    wdata=colour at clks t+1 .. t+2^(X_W+Y_W).
//   FIFO empty: we=0 and waddr/wdata hold their last values.
//  FSM CLEAR: pushes are still accepted. In the clk that issues the last address (all ones),
//   the FSM returns to IDLE and may pop the next entry with no bubble.
//   Counter wrap is internal only; the counter resets to 0 on each clear.
//  Ordering: framebuffer writes follow spi_done order exactly.
//   A SCORE may overtake earlier queued ops.
//  Latency: with an empty FIFO and IDLE, spi_done at t gives a push at t, a pop at t+1 and
//   we at t+2.
//  Upper address bits of databyte1/databyte2 beyond Y_W/X_W are ignored, not range-checked.
//  busy = (state==CLEAR) | ~fifo_empty, combinational from registers.
// TESTING
//  1 Reset: hold reset=0 with random inputs -> all outputs 0. Release, then idle 10 clks ->
//    we=0, busy=0.
//  2 PIXEL cmd=8'h15 db1=8'h03 db2=8'h1F at t -> we=1 at t+2, waddr=10'h07F, wdata=8'h05,
//    a single-clk write.
//  3 SCORE cmd=8'h20 db1=8'h02 db2=8'h9A -> next clk score=10'h29A, score_update pulses once,
//    and no we is issued.
//  4 CLEAR cmd=8'h32 then 2 PIXELs during the sweep -> 1024 writes, addr 0..1023 with
//    wdata=2, then both pixels back-to-back with no gap. busy drops the clk after the last.
//  5 CLEAR, then 5 PIXELs (DEPTH=4) during the sweep -> 4 queued and the 5th dropped,
//    overflow=1 sticky. ACK 8'hF0 -> overflow=0.
//  6 Assert reset at write 500 of a clear -> outputs 0 at once and the FIFO is emptied.
//    After release, no further writes occur.

Source files
------------

// File: rtl/spi_cmd_engine.sv
// SPI command decoder: score updates go straight to the score register; pixel writes and
// full-screen clears are queued in order and issued to the framebuffer one write per clk.
module spi_cmd_engine #(
    parameter int unsigned X_W        = 5,
    parameter int unsigned Y_W        = 5,
    parameter int unsigned COLOR_W    = 3,
    parameter int unsigned SCORE_W    = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_done,
    input  logic [7:0]           command,
    input  logic [7:0]           databyte1,
    input  logic [7:0]           databyte2,
    output logic                 we,
    output logic [X_W+Y_W-1:0]   waddr,
    output logic [7:0]           wdata,
    output logic [SCORE_W-1:0]   score,
    output logic                 score_update,
    output logic                 busy,
    output logic                 overflow
);

    localparam int unsigned ADDR_W = X_W + Y_W;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    // Queue entry: {is_clear, addr, colour}
    localparam int unsigned E_W    = 1 + ADDR_W + COLOR_W;

    localparam logic [3:0] OP_PIXEL = 4'h1;
    localparam logic [3:0] OP_SCORE = 4'h2;
    localparam logic [3:0] OP_CLEAR = 4'h3;
    localparam logic [3:0] OP_ACK   = 4'hF;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   sweep_cnt;

    logic [E_W-1:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    fifo_cnt;

    logic [3:0]          opcode;
    logic                push_req;
    logic                push_ok;
    logic                drop;
    logic                pop;
    logic                fifo_empty;
    logic                fifo_full;
    logic                sweep_last;
    logic                is_score;
    logic                is_ack;
    logic [E_W-1:0]      entry_in;
    logic [E_W-1:0]      head;
    logic                head_clear;
    logic [ADDR_W-1:0]   head_addr;
    logic [COLOR_W-1:0]  head_col;
    logic                unused_bits;

    // Command decode and queue handshake
    assign opcode     = command[7:4];
    assign push_req   = spi_done && ((opcode == OP_PIXEL) || (opcode == OP_CLEAR));
    assign is_score   = spi_done && (opcode == OP_SCORE);
    assign is_ack     = spi_done && (opcode == OP_ACK);
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign sweep_last = (sweep_cnt == '1);
    assign pop        = !fifo_empty && (state == S_IDLE);
    assign push_ok    = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;
    assign entry_in   = {(opcode == OP_CLEAR), databyte1[Y_W-1:0], databyte2[X_W-1:0],
                         command[COLOR_W-1:0]};

    assign head       = mem[rd_ptr];
    assign head_clear = head[E_W-1];
    assign head_addr  = head[COLOR_W +: ADDR_W];
    assign head_col   = head[COLOR_W-1:0];

    assign busy       = (state == S_CLEAR) || !fifo_empty;

    // Address bits above Y_W/X_W and argument bits above the colour are deliberately dropped
    assign unused_bits = ^{databyte1, databyte2, command};

    // Queue storage needs no reset: the pointers define what is valid
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= entry_in;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Dispatch FSM; a clear issues address 0 on the pop edge, so the sweep counter starts at 1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            sweep_cnt <= '0;
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        we    <= 1'b1;
                        wdata <= 8'(head_col);
                        if (head_clear) begin
                            state     <= S_CLEAR;
                            waddr     <= '0;
                            sweep_cnt <= ADDR_W'(1);
                        end else begin
                            waddr <= head_addr;
                        end
                    end else begin
                        we <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    we        <= 1'b1;
                    waddr     <= sweep_cnt;
                    sweep_cnt <= sweep_cnt + ADDR_W'(1);
                    if (sweep_last) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    we    <= 1'b0;
                end
            endcase
        end
    end

    // Score bypass path and sticky overflow flag; a drop wins over an acknowledge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            score        <= '0;
            score_update <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            score_update <= is_score;
            if (is_score) begin
                score <= SCORE_W'({databyte1, databyte2});
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (is_ack) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_engine.sv
// Directed bench for spi_cmd_engine: a table of single commands plus hand-written
// sequences for clear sweeps, queue overflow and mid-clear reset.
module tb_spi_cmd_engine;

    logic       clk;
    logic       reset;
    logic       spi_done;
    logic [7:0] command;
    logic [7:0] databyte1;
    logic [7:0] databyte2;
    logic       we;
    logic [9:0] waddr;
    logic [7:0] wdata;
    logic [9:0] score;
    logic       score_update;
    logic       busy;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    spi_cmd_engine dut (
        .clk          (clk),
        .reset        (reset),
        .spi_done     (spi_done),
        .command      (command),
        .databyte1    (databyte1),
        .databyte2    (databyte2),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .score        (score),
        .score_update (score_update),
        .busy         (busy),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] cmd;
        logic [7:0] db1;
        logic [7:0] db2;
        logic       exp_we;
        logic [9:0] exp_waddr;
        logic [7:0] exp_wdata;
        logic       exp_su;
        logic [9:0] exp_score;
    } vec_t;

    vec_t vecs[8];

    logic [7:0] p_cmd  [5] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    logic [7:0] p_db1  [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    logic [7:0] p_db2  [5] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    logic [9:0] p_addr [4] = '{10'h022, 10'h043, 10'h064, 10'h085};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] b1, input logic [7:0] b2);
        spi_done  = 1'b1;
        command   = c;
        databyte1 = b1;
        databyte2 = b2;
    endtask

    task automatic idle_in();
        spi_done  = 1'b0;
        command   = 8'h00;
        databyte1 = 8'h00;
        databyte2 = 8'h00;
    endtask

    initial begin
        int bad;
        int writes;

        vecs[0] = '{"pixel_basic",   8'h15, 8'h03, 8'h1F, 1'b1, 10'h07F, 8'h05, 1'b0, 10'h000};
        vecs[1] = '{"score_basic",   8'h20, 8'h02, 8'h9A, 1'b0, 10'h000, 8'h00, 1'b1, 10'h29A};
        vecs[2] = '{"pixel_upper",   8'h17, 8'hE4, 8'hA2, 1'b1, 10'h082, 8'h07, 1'b0, 10'h29A};
        vecs[3] = '{"op4_ignored",   8'h45, 8'h03, 8'h1F, 1'b0, 10'h000, 8'h00, 1'b0, 10'h29A};
        vecs[4] = '{"score_max",     8'h2F, 8'hFF, 8'hFF, 1'b0, 10'h000, 8'h00, 1'b1, 10'h3FF};
        vecs[5] = '{"op0_ignored",   8'h00, 8'h11, 8'h11, 1'b0, 10'h000, 8'h00, 1'b0, 10'h3FF};
        vecs[6] = '{"pixel_arg_msb", 8'h1F, 8'h00, 8'h00, 1'b1, 10'h000, 8'h07, 1'b0, 10'h3FF};
        vecs[7] = '{"pixel_corner",  8'h18, 8'h1F, 8'h1F, 1'b1, 10'h3FF, 8'h00, 1'b0, 10'h3FF};

        // Reset held with random inputs
        reset = 1'b0;
        idle_in();
        for (int i = 0; i < 6; i++) begin
            spi_done  = 1'($urandom);
            command   = 8'($urandom);
            databyte1 = 8'($urandom);
            databyte2 = 8'($urandom);
            tick();
        end
        check("rst_we",       32'(we),           32'(0));
        check("rst_waddr",    32'(waddr),        32'(0));
        check("rst_wdata",    32'(wdata),        32'(0));
        check("rst_score",    32'(score),        32'(0));
        check("rst_score_up", 32'(score_update), 32'(0));
        check("rst_busy",     32'(busy),         32'(0));
        check("rst_overflow", 32'(overflow),     32'(0));

        idle_in();
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (we !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("idle_after_reset", 32'(bad), 32'(0));

        // Single-command table
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].cmd, vecs[i].db1, vecs[i].db2);
            tick();
            idle_in();
            check({vecs[i].name, "_score_up"}, 32'(score_update), 32'(vecs[i].exp_su));
            check({vecs[i].name, "_score"},    32'(score),        32'(vecs[i].exp_score));
            check({vecs[i].name, "_we_early"}, 32'(we),           32'(0));
            tick();
            check({vecs[i].name, "_we"}, 32'(we), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                check({vecs[i].name, "_waddr"}, 32'(waddr), 32'(vecs[i].exp_waddr));
                check({vecs[i].name, "_wdata"}, 32'(wdata), 32'(vecs[i].exp_wdata));
            end
            check({vecs[i].name, "_score_up_once"}, 32'(score_update), 32'(0));
            tick();
            check({vecs[i].name, "_we_single"}, 32'(we), 32'(0));
            tick();
        end

        // Clear sweep with two pixels queued behind it
        send(8'h32, 8'h00, 8'h00);
        tick();
        idle_in();
        check("clr_busy_pending", 32'(busy), 32'(1));
        tick();
        bad = 0;
        for (int k = 0; k < 1024; k++) begin
            if (we !== 1'b1 || waddr !== 10'(k) || wdata !== 8'h02 || busy !== 1'b1) bad++;
            if (k == 10)      send(8'h14, 8'h01, 8'h02);
            else if (k == 11) send(8'h16, 8'h1F, 8'h00);
            else              idle_in();
            tick();
        end
        check("clr_sweep_bad_cycles", 32'(bad), 32'(0));
        check("clr_px1_we",    32'(we),    32'(1));
        check("clr_px1_waddr", 32'(waddr), 32'(10'h022));
        check("clr_px1_wdata", 32'(wdata), 32'(8'h04));
        check("clr_px1_busy",  32'(busy),  32'(1));
        tick();
        check("clr_px2_we",    32'(we),    32'(1));
        check("clr_px2_waddr", 32'(waddr), 32'(10'h3E0));
        check("clr_px2_wdata", 32'(wdata), 32'(8'h06));
        tick();
        check("clr_done_we",   32'(we),   32'(0));
        check("clr_done_busy", 32'(busy), 32'(0));
        tick();

        // Clear with five pixels behind it: fifth is dropped
        send(8'h33, 8'h00, 8'h00);
        tick();
        idle_in();
        tick();
        bad = 0;
        for (int k = 0; k < 1024; k++) begin
            if (we !== 1'b1 || waddr !== 10'(k) || wdata !== 8'h03) bad++;
            if (k == 14) check("ovf_before_drop", 32'(overflow), 32'(0));
            if (k >= 10 && k <= 14) send(p_cmd[k-10], p_db1[k-10], p_db2[k-10]);
            else                    idle_in();
            tick();
        end
        check("ovf_sweep_bad_cycles", 32'(bad), 32'(0));
        check("ovf_set", 32'(overflow), 32'(1));
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (we !== 1'b1 || waddr !== p_addr[i] || wdata !== 8'(i + 1)) bad++;
            tick();
        end
        check("ovf_drain_bad_writes", 32'(bad), 32'(0));
        check("ovf_drain_end_we", 32'(we), 32'(0));
        tick();
        check("ovf_no_fifth_write", 32'(we), 32'(0));
        check("ovf_sticky", 32'(overflow), 32'(1));
        send(8'hF0, 8'h00, 8'h00);
        tick();
        idle_in();
        check("ovf_ack", 32'(overflow), 32'(0));
        tick();

        // Reset in the middle of a clear, with a pixel still queued
        send(8'h31, 8'h00, 8'h00);
        tick();
        idle_in();
        tick();
        for (int k = 0; k < 500; k++) begin
            if (k == 10) send(8'h17, 8'h01, 8'h01);
            else         idle_in();
            tick();
        end
        check("mid_clr_addr", 32'(waddr), 32'(500));
        reset = 1'b0;
        #1;
        check("mid_rst_we",    32'(we),    32'(0));
        check("mid_rst_waddr", 32'(waddr), 32'(0));
        check("mid_rst_wdata", 32'(wdata), 32'(0));
        check("mid_rst_busy",  32'(busy),  32'(0));
        check("mid_rst_score", 32'(score), 32'(0));
        tick();
        tick();
        reset = 1'b1;
        writes = 0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (we !== 1'b0) writes++;
        end
        check("post_rst_writes", 32'(writes), 32'(0));
        check("post_rst_busy",   32'(busy),   32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
